// File: rtl/rv_mem_stage.sv
// rv32i MEM stage: sequences req/gnt/rvalid data-memory accesses, aligns load data, registers MEM/WB.
// Optional macro RV_MEM_MISALIGN_CHK_EN: misaligned ld/st retire as bubbles and pulse o_mem_misalign.
`ifndef XLEN
`define XLEN 32
`endif

module rv_mem_stage #(
    parameter int STALL_CNT_W = 8
) (
    input  logic                   i_clk,
    input  logic                   i_rst,
    input  logic                   i_mem_valid,
    input  logic                   i_mem_is_load,
    input  logic                   i_mem_is_store,
    input  logic [2:0]             i_mem_funct3,
    input  logic [`XLEN-1:0]       i_mem_alu_res,
    input  logic [`XLEN-1:0]       i_mem_store_data,
    input  logic                   i_mem_rf_we,
    input  logic [4:0]             i_mem_rf_wa,
    output logic                   o_dmem_req,
    output logic                   o_dmem_we,
    output logic [`XLEN-1:0]       o_dmem_addr,
    output logic [`XLEN-1:0]       o_dmem_wdata,
    output logic [3:0]             o_dmem_be,
    input  logic                   i_dmem_gnt,
    input  logic                   i_dmem_rvalid,
    input  logic [`XLEN-1:0]       i_dmem_rdata,
    output logic                   o_mem_stall,
    output logic [`XLEN-1:0]       o_mem_rf_rd_fwd,
    output logic                   o_wb_is_load,
    output logic [`XLEN-1:0]       o_wb_dmem_rd,
    output logic                   o_wb_rf_we,
    output logic [4:0]             o_wb_rf_wa,
    output logic [`XLEN-1:0]       o_wb_rf_wd_pre,
    output logic [STALL_CNT_W-1:0] o_mem_stall_cnt,
    output logic                   o_mem_misalign
);

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        WAIT_GNT = 2'd1,
        WAIT_RSP = 2'd2
    } state_t;

    function automatic logic [3:0] be_f(input logic [2:0] f3, input logic [1:0] lo);
        case (f3[1:0])
            2'b00:   return 4'b0001 << lo;
            2'b01:   return lo[1] ? 4'b1100 : 4'b0011;
            default: return 4'b1111;
        endcase
    endfunction

    function automatic logic [31:0] wdata_f(input logic [2:0] f3, input logic [31:0] d);
        case (f3[1:0])
            2'b00:   return {4{d[7:0]}};
            2'b01:   return {2{d[15:0]}};
            default: return d;
        endcase
    endfunction

    function automatic logic [31:0] load_ext_f(input logic [2:0] f3, input logic [1:0] lo,
                                               input logic [31:0] w);
        logic [7:0]  b;
        logic [15:0] h;
        case (lo)
            2'b00:   b = w[7:0];
            2'b01:   b = w[15:8];
            2'b10:   b = w[23:16];
            default: b = w[31:24];
        endcase
        h = lo[1] ? w[31:16] : w[15:0];
        case (f3)
            3'b000:  return {{24{b[7]}}, b};
            3'b001:  return {{16{h[15]}}, h};
            3'b100:  return {24'd0, b};
            3'b101:  return {16'd0, h};
            default: return w;
        endcase
    endfunction

`ifdef RV_MEM_MISALIGN_CHK_EN
    function automatic logic misalign_f(input logic [2:0] f3, input logic [1:0] lo);
        case (f3[1:0])
            2'b01:   return lo[0];
            2'b10:   return lo != 2'b00;
            default: return 1'b0;
        endcase
    endfunction
`endif

    state_t     state_r;
    logic [1:0] addr_lo_r;
    logic [2:0] funct3_r;
    logic       ldst_s;
    logic       mis_s;
    logic       mem_op_s;
    logic       issue_s;
    logic       store_done_s;
    logic       load_done_s;
    logic       stall_s;

    // Access classification and stall decision for the instruction held in EX/MEM
    always_comb begin
        ldst_s = i_mem_valid & (i_mem_is_load | i_mem_is_store);
        mis_s  = 1'b0;
`ifdef RV_MEM_MISALIGN_CHK_EN
        mis_s  = ldst_s & misalign_f(i_mem_funct3, i_mem_alu_res[1:0]);
`endif
        mem_op_s     = ldst_s & ~mis_s;
        issue_s      = mem_op_s & (state_r != WAIT_RSP);
        store_done_s = issue_s & i_mem_is_store & i_dmem_gnt;
        load_done_s  = mem_op_s & ~i_mem_is_store & (state_r == WAIT_RSP) & i_dmem_rvalid;
        stall_s      = mem_op_s & ~(store_done_s | load_done_s);
    end

    // Request phase is driven straight from EX/MEM, which stays frozen while we stall
    assign o_dmem_req      = issue_s & ~i_rst;
    assign o_dmem_we       = i_mem_is_store;
    assign o_dmem_addr     = {i_mem_alu_res[`XLEN-1:2], 2'b00};
    assign o_dmem_wdata    = wdata_f(i_mem_funct3, i_mem_store_data);
    assign o_dmem_be       = i_mem_is_store ? be_f(i_mem_funct3, i_mem_alu_res[1:0]) : 4'b0000;
    assign o_mem_stall     = stall_s;
    assign o_mem_rf_rd_fwd = i_mem_alu_res;

    // Access FSM; lane selectors are latched at grant for the response phase
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state_r   <= IDLE;
            addr_lo_r <= 2'b00;
            funct3_r  <= 3'b000;
        end else begin
            case (state_r)
                IDLE, WAIT_GNT: begin
                    if (issue_s && i_dmem_gnt) begin
                        addr_lo_r <= i_mem_alu_res[1:0];
                        funct3_r  <= i_mem_funct3;
                        state_r   <= i_mem_is_store ? IDLE : WAIT_RSP;
                    end else if (issue_s) begin
                        state_r <= WAIT_GNT;
                    end else begin
                        state_r <= IDLE;
                    end
                end
                WAIT_RSP: begin
                    if (i_dmem_rvalid) begin
                        state_r <= IDLE;
                    end else begin
                        state_r <= WAIT_RSP;
                    end
                end
                default: state_r <= IDLE;
            endcase
        end
    end

    // MEM/WB register; a stalled cycle inserts a bubble
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            o_wb_is_load   <= 1'b0;
            o_wb_dmem_rd   <= '0;
            o_wb_rf_we     <= 1'b0;
            o_wb_rf_wa     <= 5'd0;
            o_wb_rf_wd_pre <= '0;
        end else if (stall_s) begin
            o_wb_is_load <= 1'b0;
            o_wb_rf_we   <= 1'b0;
        end else begin
            o_wb_is_load   <= load_done_s;
            o_wb_rf_we     <= i_mem_valid & i_mem_rf_we & ~i_mem_is_store & ~mis_s;
            o_wb_rf_wa     <= i_mem_rf_wa;
            o_wb_rf_wd_pre <= i_mem_alu_res;
            if (load_done_s) begin
                o_wb_dmem_rd <= load_ext_f(funct3_r, addr_lo_r, i_dmem_rdata);
            end
        end
    end

    // Saturating stall-cycle counter
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            o_mem_stall_cnt <= '0;
        end else if (stall_s && (o_mem_stall_cnt != {STALL_CNT_W{1'b1}})) begin
            o_mem_stall_cnt <= o_mem_stall_cnt + {{(STALL_CNT_W-1){1'b0}}, 1'b1};
        end
    end

`ifdef RV_MEM_MISALIGN_CHK_EN
    // One-cycle misalign pulse aligned with the bubble it retires as
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            o_mem_misalign <= 1'b0;
        end else begin
            o_mem_misalign <= mis_s;
        end
    end
`else
    assign o_mem_misalign = 1'b0;
`endif

endmodule

// File: tb/tb_rv_mem_stage.sv
// Randomized bench for rv_mem_stage: transaction-level reference model of the access rules,
// checked cycle by cycle on the dmem port, stall output, MEM/WB register and stall counter.
module tb_rv_mem_stage;

    logic        clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst;
    logic        mem_valid, mem_is_load, mem_is_store, mem_rf_we;
    logic [2:0]  mem_funct3;
    logic [31:0] mem_alu_res, mem_store_data;
    logic [4:0]  mem_rf_wa;
    logic        dmem_req, dmem_we, dmem_gnt, dmem_rvalid;
    logic [31:0] dmem_addr, dmem_wdata, dmem_rdata;
    logic [3:0]  dmem_be;
    logic        mem_stall, wb_is_load, wb_rf_we, mem_misalign;
    logic [31:0] rf_rd_fwd, wb_dmem_rd, wb_rf_wd_pre;
    logic [4:0]  wb_rf_wa;
    logic [7:0]  stall_cnt;

    int n_cmp = 0;
    int n_bad = 0;
    int exp_stalls = 0;

    rv_mem_stage #(.STALL_CNT_W(8)) dut (
        .i_clk(clk), .i_rst(rst),
        .i_mem_valid(mem_valid), .i_mem_is_load(mem_is_load), .i_mem_is_store(mem_is_store),
        .i_mem_funct3(mem_funct3), .i_mem_alu_res(mem_alu_res), .i_mem_store_data(mem_store_data),
        .i_mem_rf_we(mem_rf_we), .i_mem_rf_wa(mem_rf_wa),
        .o_dmem_req(dmem_req), .o_dmem_we(dmem_we), .o_dmem_addr(dmem_addr),
        .o_dmem_wdata(dmem_wdata), .o_dmem_be(dmem_be),
        .i_dmem_gnt(dmem_gnt), .i_dmem_rvalid(dmem_rvalid), .i_dmem_rdata(dmem_rdata),
        .o_mem_stall(mem_stall), .o_mem_rf_rd_fwd(rf_rd_fwd),
        .o_wb_is_load(wb_is_load), .o_wb_dmem_rd(wb_dmem_rd), .o_wb_rf_we(wb_rf_we),
        .o_wb_rf_wa(wb_rf_wa), .o_wb_rf_wd_pre(wb_rf_wd_pre),
        .o_mem_stall_cnt(stall_cnt), .o_mem_misalign(mem_misalign)
    );

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    // Access size in bytes from funct3
    function automatic int ref_size(input int f3);
        if (f3 % 4 == 0) return 1;
        if (f3 % 4 == 1) return 2;
        return 4;
    endfunction

    // Lowest byte offset of the naturally aligned container holding the access
    function automatic int ref_off(input int f3, input int a);
        return (a / ref_size(f3)) * ref_size(f3);
    endfunction

    function automatic logic [31:0] ref_load(input int f3, input int a, input logic [31:0] w);
        longint wl, u, span;
        int     sz;
        sz   = ref_size(f3);
        wl   = longint'({32'd0, w});
        span = longint'(1) << (8 * sz);
        u    = (wl >> (8 * ref_off(f3, a))) % span;
        if (f3 < 4 && sz < 4 && u >= span / 2) u = u - span;
        return u[31:0];
    endfunction

    function automatic logic [3:0] ref_be(input int f3, input int a);
        int m;
        m = ((1 << ref_size(f3)) - 1) << ref_off(f3, a);
        return m[3:0];
    endfunction

    function automatic logic [31:0] ref_wdata(input int f3, input logic [31:0] d);
        if (ref_size(f3) == 1) return (d % 32'd256) * 32'h0101_0101;
        if (ref_size(f3) == 2) return (d % 32'd65536) * 32'h0001_0001;
        return d;
    endfunction

    function automatic bit ref_misalign(input int f3, input int a);
        return (ref_size(f3) > 1) && (a % ref_size(f3) != 0);
    endfunction

    // kind: 0 = ALU op, 1 = load, 2 = store; gdly = cycles without gnt; rdly = cycles from gnt to rvalid
    task automatic do_op(input int kind, input int f3, input logic [31:0] addr, input logic [31:0] sdata,
                         input logic we, input logic [4:0] wa, input int gdly, input int rdly,
                         input logic [31:0] rdata);
        int a = int'(addr[1:0]);
        bit mis = 1'b0;
        bit st;
`ifdef RV_MEM_MISALIGN_CHK_EN
        if (kind != 0) mis = ref_misalign(f3, a);
`endif
        mem_valid = 1'b1; mem_is_load = (kind == 1); mem_is_store = (kind == 2);
        mem_funct3 = 3'(f3); mem_alu_res = addr; mem_store_data = sdata;
        mem_rf_we = we; mem_rf_wa = wa;
        if (kind == 0 || mis) begin
            dmem_gnt = 1'($urandom_range(0, 1));
            dmem_rvalid = 1'($urandom_range(0, 1));
            dmem_rdata = $urandom;
            @(negedge clk);
            check_eq("nomem_stall", 32'(mem_stall), 32'd0);
            check_eq("nomem_req", 32'(dmem_req), 32'd0);
            check_eq("fwd", rf_rd_fwd, addr);
            @(posedge clk); #1;
            check_eq("nomem_wb_we", 32'(wb_rf_we), (kind == 0) ? 32'(we) : 32'd0);
            check_eq("nomem_wb_isld", 32'(wb_is_load), 32'd0);
            check_eq("misalign", 32'(mem_misalign), 32'(mis));
            if (kind == 0) begin
                check_eq("alu_wa", 32'(wb_rf_wa), 32'(wa));
                check_eq("alu_wd", wb_rf_wd_pre, addr);
            end
        end else begin
            for (int g = 0; g <= gdly; g++) begin
                dmem_gnt = (g == gdly);
                dmem_rvalid = 1'($urandom_range(0, 1));
                dmem_rdata = $urandom;
                @(negedge clk);
                check_eq("req", 32'(dmem_req), 32'd1);
                check_eq("we", 32'(dmem_we), 32'(kind == 2));
                check_eq("addr", dmem_addr, addr - 32'(a));
                check_eq("be", 32'(dmem_be), (kind == 2) ? 32'(ref_be(f3, a)) : 32'd0);
                if (kind == 2) check_eq("wdata", dmem_wdata, ref_wdata(f3, sdata));
                st = !(kind == 2 && g == gdly);
                check_eq("req_stall", 32'(mem_stall), 32'(st));
                if (st) exp_stalls++;
                @(posedge clk); #1;
                check_eq("req_wb_we", 32'(wb_rf_we), 32'd0);
                check_eq("req_wb_isld", 32'(wb_is_load), 32'd0);
                check_eq("req_misalign", 32'(mem_misalign), 32'd0);
            end
            if (kind == 1) begin
                for (int r = 1; r <= rdly; r++) begin
                    dmem_gnt = 1'($urandom_range(0, 1));
                    dmem_rvalid = (r == rdly);
                    dmem_rdata = (r == rdly) ? rdata : $urandom;
                    @(negedge clk);
                    check_eq("rsp_req", 32'(dmem_req), 32'd0);
                    check_eq("rsp_stall", 32'(mem_stall), 32'(r != rdly));
                    if (r != rdly) exp_stalls++;
                    @(posedge clk); #1;
                    if (r == rdly) begin
                        check_eq("ld_isld", 32'(wb_is_load), 32'd1);
                        check_eq("ld_we", 32'(wb_rf_we), 32'(we));
                        check_eq("ld_wa", 32'(wb_rf_wa), 32'(wa));
                        check_eq("ld_data", wb_dmem_rd, ref_load(f3, a, rdata));
                    end else begin
                        check_eq("rsp_wb_we", 32'(wb_rf_we), 32'd0);
                    end
                end
            end
        end
        mem_valid = 1'b0; mem_is_load = 1'b0; mem_is_store = 1'b0;
        dmem_gnt = 1'b0; dmem_rvalid = 1'b0;
        check_eq("stall_cnt", 32'(stall_cnt), (exp_stalls > 255) ? 32'd255 : 32'(exp_stalls));
    endtask

    function automatic int rand_load_f3();
        int t = $urandom_range(0, 4);
        return (t < 3) ? t : t + 1;
    endfunction

    initial begin
        // Reset with a load presented: no request may escape
        rst = 1'b1; mem_valid = 1'b1; mem_is_load = 1'b1; mem_is_store = 1'b0;
        mem_funct3 = 3'b010; mem_alu_res = 32'h0000_0200; mem_store_data = 32'd0;
        mem_rf_we = 1'b1; mem_rf_wa = 5'd3; dmem_gnt = 1'b1; dmem_rvalid = 1'b0; dmem_rdata = 32'd0;
        @(negedge clk);
        check_eq("rst_req", 32'(dmem_req), 32'd0);
        @(posedge clk); #1;
        mem_valid = 1'b0; mem_is_load = 1'b0; dmem_gnt = 1'b0;
        @(posedge clk); #1;
        check_eq("rst_wb_we", 32'(wb_rf_we), 32'd0);
        check_eq("rst_wb_isld", 32'(wb_is_load), 32'd0);
        check_eq("rst_wb_wd", wb_rf_wd_pre, 32'd0);
        check_eq("rst_wb_rd", wb_dmem_rd, 32'd0);
        check_eq("rst_cnt", 32'(stall_cnt), 32'd0);
        check_eq("rst_misalign", 32'(mem_misalign), 32'd0);
        rst = 1'b0;

        // Directed cases
        do_op(0, 0, 32'h0000_1234, 32'd0, 1'b1, 5'd5, 0, 0, 32'd0);
        do_op(1, 0, 32'h0000_0103, 32'd0, 1'b1, 5'd6, 0, 3, 32'h80FF_0000);
        check_eq("lb_cnt3", 32'(stall_cnt), 32'd3);
        do_op(2, 1, 32'h0000_0102, 32'h0000_ABCD, 1'b1, 5'd7, 2, 0, 32'd0);
        do_op(1, 5, 32'h0000_0102, 32'd0, 1'b1, 5'd8, 0, 1, 32'h8001_7FFF);
        do_op(1, 2, 32'h0000_0100, 32'd0, 1'b1, 5'd9, 1, 2, 32'h8001_7FFF);
        do_op(1, 2, 32'h0000_0101, 32'd0, 1'b1, 5'd10, 0, 1, 32'h1234_5678);

        // Reset while waiting for the response; a late rvalid must be ignored
        mem_valid = 1'b1; mem_is_load = 1'b1; mem_funct3 = 3'b010; mem_alu_res = 32'h0000_0300;
        mem_rf_we = 1'b1; mem_rf_wa = 5'd11; dmem_gnt = 1'b1;
        @(posedge clk); #1;
        rst = 1'b1; mem_valid = 1'b0; mem_is_load = 1'b0; dmem_gnt = 1'b0;
        @(negedge clk);
        check_eq("mid_rst_req", 32'(dmem_req), 32'd0);
        @(posedge clk); #1;
        rst = 1'b0; exp_stalls = 0;
        dmem_rvalid = 1'b1; dmem_rdata = 32'hDEAD_BEEF;
        @(negedge clk);
        check_eq("late_rv_stall", 32'(mem_stall), 32'd0);
        @(posedge clk); #1;
        dmem_rvalid = 1'b0;
        check_eq("late_rv_we", 32'(wb_rf_we), 32'd0);
        check_eq("late_rv_isld", 32'(wb_is_load), 32'd0);
        check_eq("late_rv_rd", wb_dmem_rd, 32'd0);
        check_eq("late_rv_cnt", 32'(stall_cnt), 32'd0);

        // Random traffic, long enough to saturate the stall counter
        for (int i = 0; i < 250; i++) begin
            int kind = $urandom_range(0, 2);
            int f3 = (kind == 1) ? rand_load_f3() : int'($urandom_range(0, 2));
            do_op(kind, f3, $urandom, $urandom, 1'($urandom_range(0, 1)), 5'($urandom_range(0, 31)),
                  $urandom_range(0, 3), $urandom_range(1, 4), $urandom);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL timeout: simulation did not complete");
        $fatal(1, "timeout");
    end

endmodule
